// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned BLOCK_BYTES     = 16;
    localparam int unsigned WORD_SEL_W      = 2;
    localparam int unsigned OFFSET_W        = 4;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned WORDS_PER_BLOCK = BLOCK_BYTES / 4;

    // One cache block viewed as words; word 0 occupies bits [31:0].
    typedef logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] block_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_e;

endpackage

// File: rtl/icache_line_array.sv
// Line storage: valid bits with async reset and bulk invalidate, tag/data
// arrays with a combinational read port and a single synchronous write port.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int unsigned LINES = 8,
    parameter int unsigned TAG_W = 25,
    parameter int unsigned IDX_W = $clog2(LINES)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output block_t           rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  block_t           wr_data_i,
    input  logic             inv_all_i
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    block_t           data_q [LINES];

    // Valid bits: cleared by reset or invalidate-all, set on a line fill.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (inv_all_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data storage; contents are don't-care until the line is valid.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache: zero-wait hits, block refill from a
// slow instruction memory on a miss, synchronous whole-cache invalidate.
module icache_direct_mapped
    import icache_pkg::*;
#(
    parameter int unsigned LINES      = 8,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned MEM_ADDR_W = 28
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  flush,
    output logic [WORD_W-1:0]     instruction,
    output logic                  busywait,
    output logic                  mem_read,
    output logic [MEM_ADDR_W-1:0] mem_address,
    input  logic [127:0]          mem_readdata,
    input  logic                  mem_busywait
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_W - OFFSET_W - IDX_W;

    state_e state_q, state_d;

    logic [WORD_SEL_W-1:0] word_sel;
    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic                  line_valid;
    logic [TAG_W-1:0]      line_tag;
    block_t                line_data;
    logic                  hit_c;
    logic                  fill_en;
    logic                  inv_all;
    logic                  unused_addr_bits;

    assign word_sel         = address[OFFSET_W-1:2];
    assign idx              = address[OFFSET_W+IDX_W-1:OFFSET_W];
    assign tag              = address[ADDR_W-1:OFFSET_W+IDX_W];
    assign unused_addr_bits = ^address[1:0];

    icache_line_array #(
        .LINES (LINES),
        .TAG_W (TAG_W),
        .IDX_W (IDX_W)
    ) u_lines (
        .clock      (clock),
        .reset      (reset),
        .rd_idx_i   (idx),
        .rd_valid_o (line_valid),
        .rd_tag_o   (line_tag),
        .rd_data_o  (line_data),
        .wr_en_i    (fill_en),
        .wr_idx_i   (idx),
        .wr_tag_i   (tag),
        .wr_data_i  (mem_readdata),
        .inv_all_i  (inv_all)
    );

    assign hit_c = line_valid && (line_tag == tag);

    // Word select out of the addressed line; zero whenever the lookup misses.
    always_comb begin
        instruction = '0;
        if (hit_c) begin
            instruction = line_data[word_sel];
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state outputs; memory signals decode straight from the
    // state register so reset drops them without waiting for a clock.
    always_comb begin
        state_d     = state_q;
        busywait    = 1'b0;
        mem_read    = 1'b0;
        mem_address = '0;
        fill_en     = 1'b0;
        inv_all     = 1'b0;
        case (state_q)
            IDLE: begin
                busywait = read && (!hit_c || flush);
                if (flush) begin
                    inv_all = 1'b1;
                end else if (read && !hit_c) begin
                    state_d = MEM_READ;
                end
            end
            MEM_READ: begin
                mem_read    = 1'b1;
                mem_address = MEM_ADDR_W'(address[ADDR_W-1:OFFSET_W]);
                busywait    = 1'b1;
                if (!mem_busywait) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                busywait = 1'b1;
                fill_en  = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Randomized scoreboard bench for icache_direct_mapped with a byte-serial
// memory model and a line-level reference cache.
module tb_icache_direct_mapped;

    logic         clock = 1'b0;
    logic         reset;
    logic         read;
    logic [31:0]  address;
    logic         flush;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    icache_direct_mapped dut (
        .clock        (clock),
        .reset        (reset),
        .read         (read),
        .address      (address),
        .flush        (flush),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: fixed program bytes at 0..7, hashed bytes elsewhere.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'd0: return 8'h13;
            32'd1: return 8'h00;
            32'd2: return 8'h80;
            32'd3: return 8'hc1;
            32'd4: return 8'h93;
            32'd5: return 8'h80;
            32'd6: return 8'h20;
            32'd7: return 8'h00;
            default: begin
                h = a * 32'h9E3779B1;
                return h[23:16] ^ a[7:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem_byte(a + 3), mem_byte(a + 2), mem_byte(a + 1), mem_byte(a)};
    endfunction

    // Byte-serial memory: busy for the first 15 cycles of a request, data
    // for the latched block is ready on the 16th and stays put afterwards.
    int unsigned  mcnt;
    logic [27:0]  mlat;
    always @(posedge clock or posedge reset) begin
        if (reset) mcnt <= 0;
        else if (mem_read) mcnt <= mcnt + 1;
        else mcnt <= 0;
    end
    always @(posedge clock) if (mem_read) mlat <= mem_address;
    assign mem_busywait = mem_read && (mcnt < 15);
    always_comb begin
        mem_readdata = '0;
        for (int i = 0; i < 16; i++) mem_readdata[8*i +: 8] = mem_byte({mlat, 4'(i)});
    end

    // Reference cache: per-line valid flag and tag, indexed by block number.
    bit          ref_valid [8];
    int unsigned ref_tag   [8];

    typedef struct {
        logic [31:0] instr;
        int          stall;
        int          mrc;
        logic [27:0] blk;
    } exp_t;
    exp_t sbq[$];
    exp_t e;

    bit mon_en = 1'b1;
    int busy_cnt = 0;
    int mr_cnt = 0;

    // Monitor: tracks stall/fetch cycles and retires one expectation per served read.
    always @(negedge clock) begin
        if (mon_en && !reset && read && !flush) begin
            if (mem_read) begin
                mr_cnt++;
                if (sbq.size() > 0) chk("mem_address", 32'(mem_address), 32'(sbq[0].blk));
            end
            if (busywait) begin
                busy_cnt++;
            end else begin
                if (sbq.size() == 0) begin
                    chk("unexpected_serve", 32'(1), 32'(0));
                end else begin
                    e = sbq.pop_front();
                    chk("instruction", instruction, e.instr);
                    chk("stall_cycles", 32'(busy_cnt), 32'(e.stall));
                    chk("mem_read_cycles", 32'(mr_cnt), 32'(e.mrc));
                end
                busy_cnt = 0;
                mr_cnt = 0;
            end
        end
    end

    task automatic ref_clear();
        for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a);
        int unsigned idx, tg;
        bit hit;
        exp_t x;
        idx = (a / 16) % 8;
        tg  = a / 128;
        hit = ref_valid[idx] && (ref_tag[idx] == tg);
        x.instr = word_at(a);
        x.stall = hit ? 0 : 18;
        x.mrc   = hit ? 0 : 16;
        x.blk   = a[31:4];
        sbq.push_back(x);
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tg;
        @(posedge clock); #1;
        read = 1'b1; address = a; flush = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock); #1;
            if (!busywait) break;
        end
        if (busywait) begin
            chk("read_timeout", 32'(busywait), 32'(0));
            sbq.delete();
        end
    endtask

    task automatic do_flush();
        @(posedge clock); #1;
        read = 1'b1; flush = 1'b1;
        @(negedge clock); #1;
        chk("flush_busywait", 32'(busywait), 32'(1));
        @(posedge clock); #1;
        flush = 1'b0; read = 1'b0;
        ref_clear();
    endtask

    task automatic reset_mid_fill(input logic [31:0] a);
        int n;
        mon_en = 1'b0;
        @(posedge clock); #1;
        read = 1'b1; address = a;
        n = 0;
        while (!mem_read && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("fill_started", 32'(mem_read), 32'(1));
        repeat (7) @(negedge clock);
        chk("still_filling", 32'(mem_read), 32'(1));
        reset = 1'b1;
        #1;
        chk("reset_mem_read", 32'(mem_read), 32'(0));
        chk("reset_mem_address", 32'(mem_address), 32'(0));
        read = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        ref_clear();
        busy_cnt = 0;
        mr_cnt = 0;
        mon_en = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        reset = 1'b1; read = 1'b0; flush = 1'b0; address = 32'h0;
        ref_clear();
        repeat (3) @(negedge clock);
        chk("rst_mem_read", 32'(mem_read), 32'(0));
        chk("rst_mem_address", 32'(mem_address), 32'(0));
        chk("rst_busywait", 32'(busywait), 32'(0));
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("cold_instruction", instruction, 32'h0);

        // Directed: cold miss, same-block hit, conflict, flush, reset mid-fill.
        do_read(32'h0);
        chk("cold_word0", instruction, 32'hc1800013);
        do_read(32'h4);
        chk("hit_word1", instruction, 32'h00208093);
        do_read(32'h80);
        do_read(32'h0);
        do_flush();
        do_read(32'h4);
        reset_mid_fill(32'h100);
        do_read(32'h0);

        // Idle: no stall and no memory traffic with read low.
        @(posedge clock); #1;
        read = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("idle_busywait", 32'(busywait), 32'(0));
            chk("idle_mem_read", 32'(mem_read), 32'(0));
        end

        // Random traffic over a few tags per index, occasional far tags and flushes.
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_flush();
            end else begin
                a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4)
                  | (32'($urandom_range(0, 3)) << 2);
                if ($urandom_range(0, 9) == 0) a = a | 32'hFFFF_F000;
                do_read(a);
            end
        end
        @(posedge clock); #1;
        read = 1'b0;
        repeat (2) @(negedge clock);
        chk("scoreboard_empty", 32'(sbq.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
